// File: rtl/signed_result_formatter_if.sv
// signed_result_formatter_if: start/operand request and formatted-result bundle.
interface signed_result_formatter_if #(
  parameter int MAG_WIDTH = 16,
  parameter int DIGITS = 5
);
  logic start;
  logic [MAG_WIDTH-1:0] magnitude;
  logic negative_flag;
  logic busy;
  logic done;
  logic sign_out;
  logic [MAG_WIDTH:0] signed_product;
  logic [DIGITS*4-1:0] bcd;
  modport master (
    output start, magnitude, negative_flag,
    input busy, done, sign_out, signed_product, bcd
  );
  modport slave (
    input start, magnitude, negative_flag,
    output busy, done, sign_out, signed_product, bcd
  );
endinterface

// File: rtl/signed_result_formatter.sv
// signed_result_formatter: serial double-dabble BCD of a product magnitude plus signed two's-complement form.
module signed_result_formatter #(
  parameter int MAG_WIDTH = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic rst,
  signed_result_formatter_if.slave bus
);
  localparam int CW = $clog2(MAG_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [MAG_WIDTH-1:0] magReg, magHold;
  logic negHold, showMinus;
  logic [DIGITS*4-1:0] scratch, adjusted;
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++)
      adjusted[i*4+:4] = scratch[i*4+:4] >= 4'd5 ? scratch[i*4+:4] + 4'd3 : scratch[i*4+:4];
  end
  // zero magnitude never shows a minus sign
  assign showMinus = negHold && |magHold;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      magReg <= '0;
      magHold <= '0;
      negHold <= 1'b0;
      scratch <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sign_out <= 1'b0;
      bus.signed_product <= '0;
      bus.bcd <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          magReg <= bus.magnitude;
          magHold <= bus.magnitude;
          negHold <= bus.negative_flag;
          scratch <= '0;
          count <= CW'(MAG_WIDTH);
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (count == '0) begin
          bus.done <= 1'b1;
          bus.bcd <= scratch;
          bus.sign_out <= showMinus;
          bus.signed_product <= showMinus ? ~{1'b0, magHold} + (MAG_WIDTH+1)'(1) : {1'b0, magHold};
          state <= DONE;
        end else begin
          {scratch, magReg} <= {adjusted, magReg} << 1;
          count <= count - CW'(1);
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_result_formatter.sv
// tb_signed_result_formatter: table vectors, random conversions vs. decimal model, multi-cycle corner sequences.
module tb_signed_result_formatter;
  localparam int MW = 16;
  localparam int DG = 5;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  signed_result_formatter_if #(.MAG_WIDTH(MW), .DIGITS(DG)) bus ();
  signed_result_formatter #(.MAG_WIDTH(MW), .DIGITS(DG)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] mag;
    logic neg;
    logic [DG*4-1:0] expBcd;
    logic expSign;
    logic [MW:0] expProd;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DG*4-1:0] refBcd(input int m);
    logic [DG*4-1:0] r = '0;
    for (int i = 0; i < DG; i++) begin
      r[i*4+:4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [MW:0] refProd(input int m, input logic n);
    int full = 1 << (MW + 1);
    return (n && m != 0) ? (MW+1)'(full - m) : (MW+1)'(m);
  endfunction

  task automatic waitDone(output int lat, output int busyDrops);
    lat = 0;
    busyDrops = 0;
    while (lat < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy !== 1'b1) busyDrops++;
    end
  endtask

  task automatic convert(input logic [MW-1:0] mag, input logic neg, input string tag);
    int lat, drops;
    bus.start = 1'b1;
    bus.magnitude = mag;
    bus.negative_flag = neg;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.magnitude = MW'($urandom);
    bus.negative_flag = ~neg;
    waitDone(lat, drops);
    check({tag, " latency"}, lat, 17);
    check({tag, " busy"}, drops, 0);
    check({tag, " bcd"}, bus.bcd, refBcd(int'(mag)));
    check({tag, " sign"}, bus.sign_out, neg && mag != 0);
    check({tag, " prod"}, bus.signed_product, refProd(int'(mag), neg));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, bus.done, 0);
    check({tag, " busy idle"}, bus.busy, 0);
  endtask

  initial begin
    vecs[0] = '{16'd56, 1'b0, 20'h00056, 1'b0, 17'h00038};
    vecs[1] = '{16'd56, 1'b1, 20'h00056, 1'b1, 17'h1FFC8};
    vecs[2] = '{16'd16384, 1'b1, 20'h16384, 1'b1, 17'h1C000};
    vecs[3] = '{16'd65535, 1'b0, 20'h65535, 1'b0, 17'h0FFFF};
    vecs[4] = '{16'd0, 1'b1, 20'h00000, 1'b0, 17'h00000};
    vecs[5] = '{16'd0, 1'b0, 20'h00000, 1'b0, 17'h00000};
    vecs[6] = '{16'd1, 1'b1, 20'h00001, 1'b1, 17'h1FFFF};
    vecs[7] = '{16'd9999, 1'b0, 20'h09999, 1'b0, 17'h0270F};
    vecs[8] = '{16'd10000, 1'b1, 20'h10000, 1'b1, 17'h1D8F0};
    vecs[9] = '{16'd32768, 1'b1, 20'h32768, 1'b1, 17'h18000};
    rst = 1'b1;
    bus.start = 1'b1;
    bus.magnitude = 16'd1234;
    bus.negative_flag = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset sign", bus.sign_out, 0);
    check("reset prod", bus.signed_product, 0);
    check("reset bcd", bus.bcd, 0);
    rst = 1'b0;
    bus.start = 1'b0;

    for (int i = 0; i < 10; i++) begin
      int lat, drops;
      bus.start = 1'b1;
      bus.magnitude = vecs[i].mag;
      bus.negative_flag = vecs[i].neg;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.magnitude = ~vecs[i].mag;
      bus.negative_flag = ~vecs[i].neg;
      waitDone(lat, drops);
      check($sformatf("vec%0d latency", i), lat, 17);
      check($sformatf("vec%0d bcd", i), bus.bcd, vecs[i].expBcd);
      check($sformatf("vec%0d sign", i), bus.sign_out, vecs[i].expSign);
      check($sformatf("vec%0d prod", i), bus.signed_product, vecs[i].expProd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done once", i), bus.done, 0);
    end

    for (int i = 0; i < 20; i++) convert(MW'($urandom_range(0, 65535)), 1'(($urandom) & 1), $sformatf("rnd%0d", i));

    begin
      int lat = 0, drops = 0;
      bus.start = 1'b1;
      bus.magnitude = 16'd4321;
      bus.negative_flag = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      while (lat < 40 && bus.done !== 1'b1) begin
        bus.start = (lat == 4);
        if (lat == 4) begin
          bus.magnitude = 16'd777;
          bus.negative_flag = 1'b0;
        end
        @(posedge clk);
        #1;
        lat++;
        if (bus.busy !== 1'b1) drops++;
      end
      bus.start = 1'b0;
      check("restart latency", lat, 17);
      check("restart busy", drops, 0);
      check("restart bcd", bus.bcd, 20'h04321);
      check("restart sign", bus.sign_out, 1);
      check("restart prod", bus.signed_product, 17'h1EF1F);
      @(posedge clk);
      #1;
      check("restart idle", bus.busy, 0);
      repeat (20) @(posedge clk);
      #1;
      check("restart no capture", bus.bcd, 20'h04321);
    end

    begin
      int lat, drops;
      bus.start = 1'b1;
      bus.magnitude = 16'd200;
      bus.negative_flag = 1'b0;
      @(posedge clk);
      #1;
      waitDone(lat, drops);
      check("held latency", lat, 17);
      check("held bcd", bus.bcd, 20'h00200);
      bus.magnitude = 16'd300;
      bus.negative_flag = 1'b1;
      waitDone(lat, drops);
      lat = 0;
      @(posedge clk);
      #1;
      waitDone(lat, drops);
      bus.start = 1'b0;
      check("held second latency", lat, 18);
      check("held second bcd", bus.bcd, 20'h00300);
      check("held second prod", bus.signed_product, 17'h1FED4);
      @(posedge clk);
      #1;
    end

    begin
      int dones = 0;
      bus.start = 1'b1;
      bus.magnitude = 16'd999;
      bus.negative_flag = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort busy", bus.busy, 0);
      check("abort done", bus.done, 0);
      check("abort sign", bus.sign_out, 0);
      check("abort prod", bus.signed_product, 0);
      check("abort bcd", bus.bcd, 0);
      for (int i = 0; i < 25; i++) begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      check("abort quiet", dones, 0);
      convert(16'd47, 1'b1, "after abort");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
